pe_controller: RTL and testbench

Instruction controller of one processing element (PE) in the CGRA fabric. Each cycle it decodes one fragment-instance instruction (op/funct plus target fields) and produces:
- ALU selects and the A/B operand values
- load requests and extracted load data
- prefix, branch, send and fragment-control signals for the PE bus
- the next instruction counter

Sits between the PE instruction store/operand bus and the ALU, result register and memory port.

---
 rtl/pe_ctrl_pkg.sv | 9 +
 rtl/pe_controller_extract.sv | 15 +
 rtl/pe_controller.sv | 161 ++++++++++++++++
 tb/tb_pe_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared opcode, target-type, prefix and load-width codes for the PE controller
package pe_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] OP_ALU = 3'b000, OP_LOAD = 3'b001, OP_SEND = 3'b010, OP_PFX_I = 3'b011;
  localparam logic [2:0] OP_PFX_T = 3'b100, OP_FEND = 3'b101, OP_FSTART = 3'b110, OP_BR = 3'b111;
  localparam logic [1:0] TT_BRZ = 2'b00, TT_NONE = 2'b01, TT_OPA = 2'b10, TT_OPB = 2'b11;
  localparam logic [1:0] PFX_NONE = 2'b00, PFX_I = 2'b10, PFX_T = 2'b01;
  localparam logic [3:0] LD_B = 4'b0000, LD_H = 4'b0001, LD_W = 4'b0010, LD_BU = 4'b0100, LD_HU = 4'b0101;
endpackage

// File: rtl/pe_controller_extract.sv
// pe_load_extract: width selection and sign/zero extension of a load response
module pe_load_extract
  import pe_ctrl_pkg::*;
(
  input  logic [3:0]      funct,
  input  logic [XLEN-1:0] msg,
  output logic [XLEN-1:0] data
);
  always_comb
    data = funct == LD_B  ? {{(XLEN-8){msg[7]}}, msg[7:0]} :
           funct == LD_H  ? {{(XLEN-16){msg[15]}}, msg[15:0]} :
           funct == LD_W  ? msg :
           funct == LD_BU ? XLEN'(msg[7:0]) :
           funct == LD_HU ? XLEN'(msg[15:0]) : '0;
endmodule

// File: rtl/pe_controller.sv
// pe_controller: per-cycle instruction decode for one CGRA PE, all outputs registered.
// Define PE_CTRL_SEND_EN to make op 010 a message send; otherwise it is a NOP.
module pe_controller #(
  parameter int XLEN = 32,
  parameter int NMSG = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           op,
  input  logic [3:0]           funct,
  input  logic                 ALU0,
  input  logic [5:0]           nalloc,
  input  logic                 endF,
  input  logic                 immab,
  input  logic [5:0]           immlo,
  input  logic [25:0]          immhi,
  input  logic [9:0]           offset,
  input  logic [5:0]           ta1, ta2, ta3, ta4,
  input  logic [1:0]           tt1, tt2, tt3, tt4,
  input  logic [1:0]           prefix_i,
  input  logic [25:0]          immhi_i,
  input  logic [1:0]           tt3_i, tt4_i,
  input  logic [5:0]           ta3_i, ta4_i,
  input  logic [1:0]           tt1_ctrl, tt2_ctrl,
  input  logic [XLEN-1:0]      result_1, result_2,
  input  logic [5:0]           icounter_i,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_Message,
  input  logic [NMSG*XLEN-1:0] messages,
  output logic                 mem_read,
  output logic [XLEN-1:0]      mem_address,
  output logic [3:0]           ALUsel,
  output logic                 Asel, Bsel,
  output logic [1:0]           Osel,
  output logic [XLEN-1:0]      Aval, Bval, messReg,
  output logic [1:0]           prefix_o,
  output logic [25:0]          immhi_o,
  output logic [1:0]           tt1_o, tt2_o, tt3_o, tt4_o,
  output logic [5:0]           ta1_o, ta2_o, ta3_o, ta4_o,
  output logic                 branch, oTerm,
  output logic [5:0]           nalloc_o,
  output logic                 endAck, Aenable, Benable, Renable,
  output logic [2:0]           outMessInd,
  output logic [25:0]          out_sendFIA,
  output logic                 invoke_on,
  output logic [5:0]           icounter_o
);
  import pe_ctrl_pkg::*;
  typedef struct packed {
    logic            mem_read;
    logic [XLEN-1:0] mem_address;
    logic [3:0]      alu_sel;
    logic            asel, bsel;
    logic [1:0]      osel;
    logic [XLEN-1:0] aval, bval, mess;
    logic [1:0]      prefix;
    logic [25:0]     immhi;
    logic [1:0]      tt1, tt2, tt3, tt4;
    logic [5:0]      ta1, ta2, ta3, ta4;
    logic            branch, oterm;
    logic [5:0]      nalloc;
    logic            end_ack, aen, ben, ren;
    logic [2:0]      mess_ind;
    logic [25:0]     send_fia;
    logic            invoke;
    logic [5:0]      icnt;
  } out_t;
  out_t d, q;
  logic [XLEN-1:0] imm, a, b, ld_data;
  logic a_r1, a_r2, b_r1, b_r2, unused;
  assign unused = ^{offset, messages};
  assign imm = prefix_i != PFX_NONE ? XLEN'({immhi_i, immlo}) : XLEN'(immlo);
  assign a_r1 = tt1_ctrl == TT_OPA;
  assign a_r2 = tt2_ctrl == TT_OPA;
  assign b_r1 = tt1_ctrl == TT_OPB;
  assign b_r2 = tt2_ctrl == TT_OPB;
  // result_1 takes priority when both writes target the same operand
  assign a = a_r1 ? result_1 : a_r2 ? result_2 : immab ? '0 : imm;
  assign b = b_r1 ? result_1 : b_r2 ? result_2 : immab ? imm : '0;
  pe_load_extract u_extract (.funct(funct), .msg(mem_Message), .data(ld_data));
  always_comb begin
    d = '0;
    if (op == OP_ALU || op == OP_LOAD) begin
      d.aval = a;
      d.bval = b;
      d.asel = a_r1 | a_r2;
      d.bsel = b_r1 | b_r2;
      d.tt1 = tt1;
      d.ta1 = ta1;
      d.tt2 = tt2;
      d.ta2 = ta2;
      d.branch = ALU0 & (tt1 == TT_BRZ | tt2 == TT_BRZ);
    end
    if (op == OP_ALU) begin
      d.alu_sel = funct;
      d.aen = 1'b1;
      d.ben = 1'b1;
      d.ren = 1'b1;
    end
    if (op == OP_LOAD) begin
      d.mem_read = !mem_ack;
      d.mem_address = a + b;
      d.ren = mem_ack;
      d.osel = mem_ack ? 2'b01 : 2'b00;
      d.mess = mem_ack ? ld_data : '0;
    end
`ifdef PE_CTRL_SEND_EN
    if (op == OP_SEND) begin
      d.mess_ind = funct[2:0];
      d.mess = messages[32'(funct[2:0]) * XLEN +: XLEN];
      d.send_fia = immhi;
      d.invoke = 1'b1;
      d.osel = 2'b10;
    end
`endif
    if (op == OP_PFX_I) begin
      d.prefix = PFX_I;
      d.immhi = immhi;
    end else if (op == OP_PFX_T) begin
      d.prefix = PFX_T;
      {d.tt3, d.tt4, d.ta3, d.ta4} = {tt3, tt4, ta3, ta4};
    end else if (prefix_i == PFX_T) begin
      {d.tt3, d.tt4, d.ta3, d.ta4} = {tt3_i, tt4_i, ta3_i, ta4_i};
    end
    if (op == OP_FEND) begin
      d.end_ack = endF;
      d.oterm = endF;
    end
    if (op == OP_FSTART) d.nalloc = nalloc;
    if (op == OP_BR) begin
      d.branch = 1'b1;
      d.ta1 = ta1;
    end
    d.icnt = d.branch ? ta1 : icounter_i + 6'd1;
  end
  always_ff @(posedge clk) q <= reset ? '0 : d;
  assign mem_read = q.mem_read;
  assign mem_address = q.mem_address;
  assign ALUsel = q.alu_sel;
  assign Asel = q.asel;
  assign Bsel = q.bsel;
  assign Osel = q.osel;
  assign Aval = q.aval;
  assign Bval = q.bval;
  assign messReg = q.mess;
  assign prefix_o = q.prefix;
  assign immhi_o = q.immhi;
  assign {tt1_o, tt2_o, tt3_o, tt4_o} = {q.tt1, q.tt2, q.tt3, q.tt4};
  assign {ta1_o, ta2_o, ta3_o, ta4_o} = {q.ta1, q.ta2, q.ta3, q.ta4};
  assign branch = q.branch;
  assign oTerm = q.oterm;
  assign nalloc_o = q.nalloc;
  assign endAck = q.end_ack;
  assign Aenable = q.aen;
  assign Benable = q.ben;
  assign Renable = q.ren;
  assign outMessInd = q.mess_ind;
  assign out_sendFIA = q.send_fia;
  assign invoke_on = q.invoke;
  assign icounter_o = q.icnt;
endmodule

// File: tb/tb_pe_controller.sv
// tb_pe_controller: directed scoreboard bench for pe_controller
module tb_pe_controller;
  localparam int XLEN = 32;
  localparam int NMSG = 8;
  localparam int F_MRD = 0, F_MADDR = 1, F_ALUSEL = 2, F_ASEL = 3, F_BSEL = 4, F_OSEL = 5, F_AVAL = 6;
  localparam int F_BVAL = 7, F_MESS = 8, F_PFX = 9, F_IMMHI = 10, F_TT1 = 11, F_TA1 = 12, F_TT3 = 13;
  localparam int F_TA3 = 14, F_TT4 = 15, F_TA4 = 16, F_BR = 17, F_OTERM = 18, F_NALLOC = 19, F_EACK = 20;
  localparam int F_AEN = 21, F_BEN = 22, F_REN = 23, F_MIND = 24, F_FIA = 25, F_INV = 26, F_ICNT = 27;
  string names [28] = '{"mem_read", "mem_address", "ALUsel", "Asel", "Bsel", "Osel", "Aval", "Bval",
                        "messReg", "prefix_o", "immhi_o", "tt1_o", "ta1_o", "tt3_o", "ta3_o", "tt4_o",
                        "ta4_o", "branch", "oTerm", "nalloc_o", "endAck", "Aenable", "Benable",
                        "Renable", "outMessInd", "out_sendFIA", "invoke_on", "icounter_o"};
  logic clk = 0, reset;
  logic [2:0] op;
  logic [3:0] funct;
  logic ALU0, endF, immab, mem_ack;
  logic [5:0] nalloc, immlo, ta1, ta2, ta3, ta4, ta3_i, ta4_i, icounter_i;
  logic [25:0] immhi, immhi_i;
  logic [9:0] offset;
  logic [1:0] tt1, tt2, tt3, tt4, prefix_i, tt3_i, tt4_i, tt1_ctrl, tt2_ctrl;
  logic [XLEN-1:0] result_1, result_2, mem_Message;
  logic [NMSG*XLEN-1:0] messages;
  logic mem_read, Asel, Bsel, branch, oTerm, endAck, Aenable, Benable, Renable, invoke_on;
  logic [XLEN-1:0] mem_address, Aval, Bval, messReg;
  logic [3:0] ALUsel;
  logic [1:0] Osel, prefix_o, tt1_o, tt2_o, tt3_o, tt4_o;
  logic [25:0] immhi_o, out_sendFIA;
  logic [5:0] ta1_o, ta2_o, ta3_o, ta4_o, nalloc_o, icounter_o;
  logic [2:0] outMessInd;
  typedef struct { string tag; int f; logic [31:0] v; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  string cur;
  always #5 clk = ~clk;
  pe_controller #(.XLEN(XLEN), .NMSG(NMSG)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .ALU0(ALU0), .nalloc(nalloc), .endF(endF),
    .immab(immab), .immlo(immlo), .immhi(immhi), .offset(offset),
    .ta1(ta1), .ta2(ta2), .ta3(ta3), .ta4(ta4), .tt1(tt1), .tt2(tt2), .tt3(tt3), .tt4(tt4),
    .prefix_i(prefix_i), .immhi_i(immhi_i), .tt3_i(tt3_i), .tt4_i(tt4_i), .ta3_i(ta3_i), .ta4_i(ta4_i),
    .tt1_ctrl(tt1_ctrl), .tt2_ctrl(tt2_ctrl), .result_1(result_1), .result_2(result_2),
    .icounter_i(icounter_i), .mem_ack(mem_ack), .mem_Message(mem_Message), .messages(messages),
    .mem_read(mem_read), .mem_address(mem_address), .ALUsel(ALUsel), .Asel(Asel), .Bsel(Bsel),
    .Osel(Osel), .Aval(Aval), .Bval(Bval), .messReg(messReg), .prefix_o(prefix_o), .immhi_o(immhi_o),
    .tt1_o(tt1_o), .tt2_o(tt2_o), .tt3_o(tt3_o), .tt4_o(tt4_o),
    .ta1_o(ta1_o), .ta2_o(ta2_o), .ta3_o(ta3_o), .ta4_o(ta4_o), .branch(branch), .oTerm(oTerm),
    .nalloc_o(nalloc_o), .endAck(endAck), .Aenable(Aenable), .Benable(Benable), .Renable(Renable),
    .outMessInd(outMessInd), .out_sendFIA(out_sendFIA), .invoke_on(invoke_on), .icounter_o(icounter_o)
  );
  function automatic logic [31:0] obs(int f);
    case (f)
      F_MRD: return 32'(mem_read);
      F_MADDR: return mem_address;
      F_ALUSEL: return 32'(ALUsel);
      F_ASEL: return 32'(Asel);
      F_BSEL: return 32'(Bsel);
      F_OSEL: return 32'(Osel);
      F_AVAL: return Aval;
      F_BVAL: return Bval;
      F_MESS: return messReg;
      F_PFX: return 32'(prefix_o);
      F_IMMHI: return 32'(immhi_o);
      F_TT1: return 32'(tt1_o);
      F_TA1: return 32'(ta1_o);
      F_TT3: return 32'(tt3_o);
      F_TA3: return 32'(ta3_o);
      F_TT4: return 32'(tt4_o);
      F_TA4: return 32'(ta4_o);
      F_BR: return 32'(branch);
      F_OTERM: return 32'(oTerm);
      F_NALLOC: return 32'(nalloc_o);
      F_EACK: return 32'(endAck);
      F_AEN: return 32'(Aenable);
      F_BEN: return 32'(Benable);
      F_REN: return 32'(Renable);
      F_MIND: return 32'(outMessInd);
      F_FIA: return 32'(out_sendFIA);
      F_INV: return 32'(invoke_on);
      default: return 32'(icounter_o);
    endcase
  endfunction
  task automatic want(int f, logic [31:0] v);
    exp_t e;
    e.tag = cur;
    e.f = f;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs(e.f) === e.v) else begin
        errors++;
        $error("FAIL %s.%s observed=%h expected=%h", e.tag, names[e.f], obs(e.f), e.v);
      end
    end
  endtask
  task automatic clear();
    reset = 0; op = 0; funct = 0; ALU0 = 0; endF = 0; immab = 0; mem_ack = 0;
    nalloc = 0; immlo = 0; immhi = 0; immhi_i = 0; offset = 0;
    {ta1, ta2, ta3, ta4, ta3_i, ta4_i, icounter_i} = '0;
    {tt1, tt2, tt3, tt4, prefix_i, tt3_i, tt4_i, tt1_ctrl, tt2_ctrl} = '0;
    result_1 = 0; result_2 = 0; mem_Message = 0; messages = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] lf [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd3, 4'd15};
    logic [31:0] lm [7] = '{32'h12348795, 32'h12348765, 32'h12348765, 32'h12348795,
                            32'h12348765, 32'h12348765, 32'h12348765};
    logic [31:0] le [7] = '{32'hFFFFFF95, 32'hFFFF8765, 32'h12348765, 32'h00000095,
                            32'h00008765, 32'h0, 32'h0};
    clear();
    cur = "reset"; reset = 1; op = 3'b001; funct = 4'd2; tt1_ctrl = 2'b10; result_1 = 32'h55;
    want(F_ICNT, 0); want(F_MRD, 0); want(F_MADDR, 0); want(F_AVAL, 0); want(F_ALUSEL, 0);
    want(F_PFX, 0); want(F_INV, 0); want(F_REN, 0); want(F_BR, 0); want(F_MESS, 0);
    tick();
    clear();
    cur = "alu"; funct = 4'd1; immlo = 6'd4; tt1_ctrl = 2'b11; result_1 = 4; icounter_i = 1;
    tt1 = 2'b10; ta1 = 4; tt2 = 2'b01;
    want(F_ALUSEL, 1); want(F_AVAL, 4); want(F_ASEL, 0); want(F_BVAL, 4); want(F_BSEL, 1);
    want(F_AEN, 1); want(F_BEN, 1); want(F_REN, 1); want(F_OSEL, 0); want(F_TT1, 2);
    want(F_TA1, 4); want(F_ICNT, 2); want(F_BR, 0); want(F_MRD, 0);
    tick();
    clear();
    cur = "alu_prio"; funct = 4'd9; immlo = 6'd7; tt1_ctrl = 2'b10; result_1 = 11;
    tt2_ctrl = 2'b10; result_2 = 22; tt1 = 2'b01; tt2 = 2'b01; icounter_i = 10;
    want(F_ALUSEL, 9); want(F_AVAL, 11); want(F_ASEL, 1); want(F_BVAL, 0); want(F_BSEL, 0);
    want(F_ICNT, 11);
    tick();
    clear();
    cur = "ld_wait"; op = 3'b001; funct = 4'd4; immab = 1; immlo = 2; prefix_i = 2'b01; immhi_i = 1;
    tt1_ctrl = 2'b10; result_1 = 4; tt1 = 2'b01; tt2 = 2'b01; tt3_i = 3; ta3_i = 5; tt4_i = 2; ta4_i = 6;
    want(F_MRD, 1); want(F_MADDR, 70); want(F_REN, 0); want(F_OSEL, 0); want(F_ALUSEL, 0);
    want(F_TT3, 3); want(F_TA3, 5); want(F_TT4, 2); want(F_TA4, 6); want(F_PFX, 0);
    tick();
    cur = "ld_ack"; mem_ack = 1; mem_Message = 32'hAAAAAAAA;
    want(F_MRD, 0); want(F_BVAL, 66); want(F_AVAL, 4); want(F_MADDR, 70); want(F_MESS, 32'hAA);
    want(F_REN, 1); want(F_OSEL, 1);
    tick();
    for (int i = 0; i < 7; i++) begin
      clear();
      cur = $sformatf("ld_f%0d", lf[i]);
      op = 3'b001; funct = lf[i]; mem_ack = 1; mem_Message = lm[i]; tt1 = 2'b01; tt2 = 2'b01;
      icounter_i = 6'(i);
      want(F_MESS, le[i]); want(F_ICNT, 32'(i + 1)); want(F_OSEL, 1);
      tick();
    end
    clear();
    cur = "ld_wrap"; op = 3'b001; tt1_ctrl = 2'b10; result_1 = 32'hFFFFFFFF; tt2_ctrl = 2'b11;
    result_2 = 2; icounter_i = 63; tt1 = 2'b01; tt2 = 2'b01;
    want(F_MADDR, 1); want(F_ICNT, 0); want(F_MRD, 1);
    tick();
    clear();
    cur = "brz_take"; tt1 = 2'b00; ta1 = 9; tt2 = 2'b01; ALU0 = 1; icounter_i = 5;
    want(F_BR, 1); want(F_ICNT, 9); want(F_TA1, 9);
    tick();
    cur = "brz_not"; ALU0 = 0;
    want(F_BR, 0); want(F_ICNT, 6);
    tick();
    clear();
    cur = "br"; op = 3'b111; ta1 = 17; icounter_i = 3;
    want(F_BR, 1); want(F_TA1, 17); want(F_ICNT, 17);
    tick();
    clear();
    cur = "pfx_i"; op = 3'b011; immhi = 5;
    want(F_PFX, 2); want(F_IMMHI, 5); want(F_BR, 0);
    tick();
    clear();
    cur = "pfx_t"; op = 3'b100; tt3 = 2; ta3 = 7; tt4 = 3; ta4 = 8;
    want(F_PFX, 1); want(F_TT3, 2); want(F_TA3, 7); want(F_TT4, 3); want(F_TA4, 8); want(F_IMMHI, 0);
    tick();
    clear();
    cur = "fstart"; op = 3'b110; nalloc = 3; icounter_i = 20;
    want(F_NALLOC, 3); want(F_ICNT, 21); want(F_PFX, 0);
    tick();
    clear();
    cur = "fend"; op = 3'b101; endF = 1;
    want(F_EACK, 1); want(F_OTERM, 1); want(F_NALLOC, 0);
    tick();
    clear();
    cur = "send"; op = 3'b010; funct = 4'b0011; immhi = 7; icounter_i = 30;
    messages[3*XLEN +: XLEN] = 32'hDEADBEEF;
`ifdef PE_CTRL_SEND_EN
    want(F_MIND, 3); want(F_MESS, 32'hDEADBEEF); want(F_FIA, 7); want(F_INV, 1); want(F_OSEL, 2);
`else
    want(F_MIND, 0); want(F_MESS, 0); want(F_FIA, 0); want(F_INV, 0); want(F_OSEL, 0);
`endif
    want(F_ICNT, 31);
    tick();
    clear();
    cur = "rst_ld"; op = 3'b001; tt1 = 2'b01; tt2 = 2'b01;
    want(F_MRD, 1);
    tick();
    reset = 1;
    want(F_MRD, 0); want(F_ICNT, 0);
    tick();
    clear();
    cur = "late_ack"; op = 3'b101; mem_ack = 1; mem_Message = 32'h12345678;
    want(F_MRD, 0); want(F_MESS, 0); want(F_REN, 0); want(F_OSEL, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
